expr_string_gen: RTL and testbench
==================================

// Module: expr_string_gen
// PURPOSE
//  Transmit side of the one-char-per-clock ASCII expression stream. Serialises a packed
//  operand/operator request into the grammar digit ( ('+'|'*') digit )*, one byte per handshake.
//  Drives the char-stream recogniser and bench stimulus.
//  Every accepted request produces a string the recogniser accepts, ending in its accept state.
// PARAMETERS
//  MAX_TERMS  8  maximum number of digit operands per request (>=1)
//  NW         4  width of n_terms; must be >= $clog2(MAX_TERMS+1)
// PORTS
//  clk        in   1              single clock, rising edge
//  clr        in   1              reset, asynchronous, active-high
//  start      in   1              request strobe; sampled only in IDLE
//  n_terms    in   NW             number of digits in expression (1..MAX_TERMS)
//  digits     in   4*MAX_TERMS    operand k = digits[4k+3:4k], BCD 0..9; k=0 emitted first
//  ops        in   MAX_TERMS-1    op k between digit k and k+1: 0='+' (8'h2B), 1='*' (8'h2A)
//  out_char   out  8              ASCII byte presented to the stream
//  out_valid  out  1              out_char valid
//  out_ready  in   1              downstream accepts out_char this cycle
//  out_last   out  1              qualifies out_char as the final digit of the string
//  busy       out  1              request in progress (not IDLE)
//  done       out  1              one-cycle pulse: whole string transferred
//  err        out  1              one-cycle pulse: request rejected
// BEHAVIOUR
//  - Reset (clr=1, any time, async):
//    - state=IDLE; every output 0; out_char=8'h00.
//    - Any in-flight string is abandoned; no done is pulsed.
//  - Start acceptance (IDLE, start=1):
//    - Validate n_terms in 1..MAX_TERMS and every used digit (k<n_terms) <= 9.
//    - Invalid: err=1 next cycle, stay IDLE, nothing emitted.
//    - Valid: register digits/ops/n_terms (inputs may change afterwards).
//      Go to DIG, term index idx=0; out_valid=1 on the next cycle.
//  - start is ignored while busy; it is not queued.
//  - FSM states IDLE, DIG, OP, FIN:
//    - DIG: out_char = 8'h30 + digit[idx]; out_last = (idx==n_terms-1).
//      On handshake: if last -> FIN, else -> OP.
//    - OP: out_char = ops[idx] ? "*" : "+". On handshake: idx++, -> DIG.
//    - FIN: out_valid=0, done=1 for exactly one cycle, busy=1; then -> IDLE.
//  - Handshake = out_valid & out_ready.
//    - While out_valid & !out_ready, out_char and out_last hold stable.
//    - out_valid never drops without a handshake.
//  - Throughput: with out_ready=1, 2*n_terms-1 chars on consecutive cycles.
//    done follows one cycle after the last char; IDLE again the cycle after done.
//  - busy=1 from the cycle after start is accepted through the done cycle.
//  - Earliest new start is accepted the cycle after done, so back-to-back strings
//    have a >=2-cycle gap.
//  - out_ready is don't-care when out_valid=0.
//  - ops bits at index >= n_terms-1 are ignored; n_terms=1 emits a single digit with out_last=1.
// STRUCTURE
//  - Shared package/defines: ASCII_0=8'h30, ASCII_PLUS=8'h2B, ASCII_STAR=8'h2A,
//    state encodings, OP_ADD=1'b0, OP_MUL=1'b1.
//  - One sub-module, expr_char_enc (combinational): {is_op, digit[3:0], op} -> 8-bit ASCII.
//    It is shared with the bench scoreboard.
//  - Top holds the FSM, idx counter ($clog2(MAX_TERMS) bits), request registers and validation.
// TESTING
//  1. n_terms=3, digits={..,4,7,2}, ops=2'b10, out_ready=1 -> "2","+","7","*","4"
//     on 5 consecutive cycles. out_last only on "4"; done 1 cycle later.
//     Recogniser fed in parallel ends with out=1.
//  2. n_terms=1, digit0=9 -> single "9" (8'h39) with out_last=1, then done pulse.
//  3. Case 1 with out_ready toggling 1,0,0,1,0,1... -> out_char stable during stalls.
//     Same 5 bytes, none duplicated or dropped.
//  4. n_terms=0; n_terms=9; n_terms=2 with digit1=4'hA -> err pulse each time,
//     out_valid stays 0, busy stays 0.
//  5. clr asserted asynchronously mid-string (after 2nd char) -> outputs 0 immediately, no done.
//     A new start after release emits a fresh string from digit 0.
//  6. start held high during case 1 -> exactly one string.
//     A second string starts only after done, with the >=2-cycle gap.

Source files
------------

// File: rtl/expr_string_gen_pkg.sv
// Shared constants and types for the expression string generator.
//   ASCII_*  : byte codes emitted on the character stream
//   OP_*     : operator select encoding (one bit per operator slot)
//   state_t  : generator FSM state encoding
package expr_string_gen_pkg;

   localparam logic [7:0] ASCII_0    = 8'h30;
   localparam logic [7:0] ASCII_PLUS = 8'h2B;
   localparam logic [7:0] ASCII_STAR = 8'h2A;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_MUL = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIG  = 2'd1,
      ST_OP   = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

endpackage

// File: rtl/expr_string_gen_if.sv
// Character stream bundle, one ASCII byte per valid/ready handshake.
//   out_char  : ASCII byte
//   out_valid : out_char is valid
//   out_ready : sink accepts out_char this cycle
//   out_last  : out_char is the final digit of the expression
interface expr_string_gen_if;
   logic [7:0] out_char;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   modport master (output out_char, output out_valid, output out_last, input out_ready);
   modport slave  (input out_char, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/expr_char_enc.sv
// Combinational ASCII encoder for one stream symbol.
//   is_op : 1 selects the operator character, 0 the digit character
//   digit : BCD operand 0..9
//   op    : operator select (OP_ADD -> '+', OP_MUL -> '*')
//   ascii : encoded byte
module expr_char_enc
   import expr_string_gen_pkg::*;
(
   input  logic       is_op,
   input  logic [3:0] digit,
   input  logic       op,
   output logic [7:0] ascii
);

   always_comb begin
      ascii = ASCII_0 + {4'h0, digit};
      if (is_op) begin
         ascii = (op == OP_MUL) ? ASCII_STAR : ASCII_PLUS;
      end
   end

endmodule

// File: rtl/expr_string_gen.sv
// Serialises a packed operand/operator request into digit (op digit)* on a
// one-byte-per-handshake stream.
//   clk, clr      : clock, asynchronous active-high reset
//   start         : request strobe, sampled only when idle
//   n_terms       : number of digit operands (1..MAX_TERMS)
//   digits        : operand k in digits[4k+3:4k], k=0 sent first
//   ops           : operator k between digit k and k+1
//   stream        : character stream (master side)
//   busy/done/err : status; done and err are one-cycle pulses
//
// state   | meaning
// IDLE    | waiting for start, validates request
// DIG     | presenting digit[idx]
// OP      | presenting operator ops[idx]
// FIN     | string fully transferred, done pulse
module expr_string_gen
   import expr_string_gen_pkg::*;
#(
   parameter int MAX_TERMS = 8,
   parameter int NW        = 4
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic                   start,
   input  logic [NW-1:0]          n_terms,
   input  logic [4*MAX_TERMS-1:0] digits,
   input  logic [MAX_TERMS-2:0]   ops,
   expr_string_gen_if.master      stream,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int IW = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;

   state_t                 state, state_next;
   logic [IW-1:0]          idx, idx_next;
   logic [NW-1:0]          n_terms_q;
   logic [4*MAX_TERMS-1:0] digits_q;
   logic [MAX_TERMS-1:0]   ops_q;
   logic                   err_q, err_next;
   logic                   load;
   logic                   req_ok;
   logic                   is_last;
   logic                   hs;
   logic [3:0]             cur_digit;
   logic                   cur_op;
   logic [7:0]             enc_char;

   // Only the digits that will actually be sent must be BCD.
   always_comb begin
      req_ok = (n_terms != '0) && (n_terms <= NW'(MAX_TERMS));
      for (int k = 0; k < MAX_TERMS; k++) begin
         if ((NW'(k) < n_terms) && (digits[4*k +: 4] > 4'd9)) begin
            req_ok = 1'b0;
         end
      end
   end

   assign cur_digit = digits_q[{idx, 2'b00} +: 4];
   assign cur_op    = ops_q[idx];
   assign is_last   = (NW'(idx) + NW'(1)) == n_terms_q;
   assign hs        = stream.out_valid & stream.out_ready;

   expr_char_enc u_enc (
      .is_op (state == ST_OP),
      .digit (cur_digit),
      .op    (cur_op),
      .ascii (enc_char)
   );

   always_comb begin
      state_next = state;
      idx_next   = idx;
      load       = 1'b0;
      err_next   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (req_ok) begin
                  load       = 1'b1;
                  idx_next   = '0;
                  state_next = ST_DIG;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         ST_DIG: begin
            if (hs) begin
               state_next = is_last ? ST_FIN : ST_OP;
            end
         end
         ST_OP: begin
            if (hs) begin
               idx_next   = idx + IW'(1);
               state_next = ST_DIG;
            end
         end
         ST_FIN:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= ST_IDLE;
         idx       <= '0;
         err_q     <= 1'b0;
         n_terms_q <= '0;
         digits_q  <= '0;
         ops_q     <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         err_q <= err_next;
         if (load) begin
            n_terms_q <= n_terms;
            digits_q  <= digits;
            ops_q     <= {1'b0, ops};
         end
      end
   end

   // Outputs decode straight from state so clr forces them low immediately.
   assign stream.out_valid = (state == ST_DIG) || (state == ST_OP);
   assign stream.out_char  = stream.out_valid ? enc_char : 8'h00;
   assign stream.out_last  = (state == ST_DIG) && is_last;
   assign busy             = (state != ST_IDLE);
   assign done             = (state == ST_FIN);
   assign err              = err_q;

endmodule

// File: tb/tb_expr_string_gen.sv
module tb_expr_string_gen;

   logic        clk;
   logic        clr;
   logic        start;
   logic [3:0]  n_terms;
   logic [31:0] digits;
   logic [6:0]  ops;
   logic        busy, done, err;

   logic        e_is_op;
   logic [3:0]  e_digit;
   logic        e_op;
   logic [7:0]  e_ascii;

   int n_tests = 0;
   int n_fail  = 0;

   expr_string_gen_if bus();

   expr_string_gen #(.MAX_TERMS(8), .NW(4)) dut (
      .clk     (clk),
      .clr     (clr),
      .start   (start),
      .n_terms (n_terms),
      .digits  (digits),
      .ops     (ops),
      .stream  (bus),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   expr_char_enc u_enc_chk (
      .is_op (e_is_op),
      .digit (e_digit),
      .op    (e_op),
      .ascii (e_ascii)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_req(input logic [3:0] n, input logic [31:0] d, input logic [6:0] o,
                            input bit hold);
      start   = 1'b1;
      n_terms = n;
      digits  = d;
      ops     = o;
      step();
      if (!hold) begin
         start   = 1'b0;
         n_terms = 4'd0;
         digits  = 32'hFFFF_FFFF;
         ops     = ~o;
      end
   endtask

   // Drains one string, checking bytes, out_last, stall stability, done timing
   // and grammar acceptance. Returns in the done cycle.
   task automatic check_stream(input string name, input string exp, input bit toggle);
      int         got, cyc, last_cyc, rdy_i, rec;
      bit         stalled, seen_done;
      logic [7:0] held;
      logic [7:0] want;
      logic [5:0] pat;
      pat = 6'b101001;
      got = 0; cyc = 0; last_cyc = -10; rdy_i = 0; rec = 0;
      stalled = 0; seen_done = 0; held = 8'h00;
      while (!seen_done && cyc < 200) begin
         bus.out_ready = toggle ? pat[rdy_i % 6] : 1'b1;
         rdy_i++;
         if (stalled) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_char !== held) begin
               n_fail++;
               $display("FAIL %s stall_hold: valid=%b char=%h, required valid=1 char=%h",
                        name, bus.out_valid, bus.out_char, held);
            end
         end
         if (bus.out_valid === 1'b1) begin
            n_tests++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL %s busy_while_valid: got %b required 1", name, busy);
            end
            if (bus.out_ready) begin
               if (got < exp.len()) begin
                  want = 8'(exp[got]);
                  n_tests++;
                  if (bus.out_char !== want) begin
                     n_fail++;
                     $display("FAIL %s char[%0d]: got %h required %h", name, got, bus.out_char, want);
                  end
                  n_tests++;
                  if (bus.out_last !== (got == exp.len() - 1)) begin
                     n_fail++;
                     $display("FAIL %s last[%0d]: got %b required %b", name, got, bus.out_last,
                              (got == exp.len() - 1));
                  end
               end else begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL %s extra_char: got %h required none", name, bus.out_char);
               end
               if (bus.out_char >= 8'h30 && bus.out_char <= 8'h39) rec = (rec == 0) ? 1 : 2;
               else if (bus.out_char == 8'h2B || bus.out_char == 8'h2A) rec = (rec == 1) ? 0 : 2;
               else rec = 2;
               got++;
               last_cyc = cyc;
               stalled  = 0;
            end else begin
               stalled = 1;
               held    = bus.out_char;
            end
         end
         if (done === 1'b1) begin
            seen_done = 1;
            n_tests++;
            if (cyc != last_cyc + 1 || got != exp.len()) begin
               n_fail++;
               $display("FAIL %s done_timing: chars=%0d gap=%0d, required chars=%0d gap=1",
                        name, got, cyc - last_cyc, exp.len());
            end
         end else begin
            step();
            cyc++;
         end
      end
      bus.out_ready = 1'b1;
      n_tests++;
      if (!seen_done) begin
         n_fail++;
         $display("FAIL %s done_timeout: no done within 200 cycles, got %0d chars", name, got);
      end
      n_tests++;
      if (rec != 1) begin
         n_fail++;
         $display("FAIL %s recogniser: end state %0d required 1 (accept)", name, rec);
      end
   endtask

   task automatic test_reset();
      #3;
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.out_char !== 8'h00 || bus.out_last !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b char=%h last=%b busy=%b done=%b err=%b required all 0",
                  bus.out_valid, bus.out_char, bus.out_last, busy, done, err);
      end
      @(negedge clk);
      clr = 1'b0;
      step();
   endtask

   task automatic test_enc();
      logic [3:0] dv [4];
      logic       iv [4];
      logic       ov [4];
      logic [7:0] ev [4];
      dv = '{4'd0, 4'd9, 4'd5, 4'd5};
      iv = '{1'b0, 1'b0, 1'b1, 1'b1};
      ov = '{1'b1, 1'b0, 1'b0, 1'b1};
      ev = '{8'h30, 8'h39, 8'h2B, 8'h2A};
      for (int i = 0; i < 4; i++) begin
         e_is_op = iv[i];
         e_digit = dv[i];
         e_op    = ov[i];
         #1;
         n_tests++;
         if (e_ascii !== ev[i]) begin
            n_fail++;
            $display("FAIL enc[%0d]: got %h required %h", i, e_ascii, ev[i]);
         end
      end
   endtask

   task automatic test_basic();
      start_req(4'd3, 32'h0000_0472, 7'b0000010, 0);
      check_stream("basic", "2+7*4", 0);
      step();
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_idle_after: busy=%b done=%b valid=%b required 0 0 0",
                  busy, done, bus.out_valid);
      end
   endtask

   task automatic test_single();
      start_req(4'd1, 32'h0000_0009, 7'h7F, 0);
      check_stream("single", "9", 0);
      step();
   endtask

   task automatic test_stall();
      start_req(4'd3, 32'h0000_0472, 7'b0000010, 0);
      check_stream("stall", "2+7*4", 1);
      step();
   endtask

   task automatic test_invalid();
      logic [3:0]  nv [3];
      logic [31:0] dv [3];
      nv = '{4'd0, 4'd9, 4'd2};
      dv = '{32'h0000_0001, 32'h1111_1111, 32'h0000_00A3};
      for (int i = 0; i < 3; i++) begin
         start_req(nv[i], dv[i], 7'h00, 0);
         n_tests++;
         if (err !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid[%0d]: err=%b valid=%b busy=%b required 1 0 0",
                     i, err, bus.out_valid, busy);
         end
         step();
         n_tests++;
         if (err !== 1'b0 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_after[%0d]: err=%b valid=%b busy=%b required 0 0 0",
                     i, err, bus.out_valid, busy);
         end
      end
   endtask

   task automatic test_clr_mid();
      bus.out_ready = 1'b1;
      start_req(4'd3, 32'h0000_0472, 7'b0000010, 0);
      step();
      step();
      n_tests++;
      if (bus.out_char !== 8'h37 || bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_pre: char=%h valid=%b required 37 1", bus.out_char, bus.out_valid);
      end
      #2;
      clr = 1'b1;
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.out_char !== 8'h00 || bus.out_last !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_async: valid=%b char=%h last=%b busy=%b done=%b required all 0",
                  bus.out_valid, bus.out_char, bus.out_last, busy, done);
      end
      @(negedge clk);
      clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_tests++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_no_done[%0d]: done=%b busy=%b required 0 0", i, done, busy);
         end
      end
      start_req(4'd3, 32'h0000_0472, 7'b0000010, 0);
      check_stream("clr_restart", "2+7*4", 0);
      step();
   endtask

   task automatic test_start_held();
      start_req(4'd3, 32'h0000_0472, 7'b0000010, 1);
      check_stream("held_first", "2+7*4", 0);
      step();
      n_tests++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL held_gap: valid=%b busy=%b done=%b required 0 0 0",
                  bus.out_valid, busy, done);
      end
      step();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_char !== 8'h32) begin
         n_fail++;
         $display("FAIL held_second_start: valid=%b char=%h required 1 32",
                  bus.out_valid, bus.out_char);
      end
      start = 1'b0;
      check_stream("held_second", "2+7*4", 0);
      step();
      step();
      n_tests++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL held_no_third: valid=%b busy=%b required 0 0", bus.out_valid, busy);
      end
   endtask

   initial begin
      clr           = 1'b1;
      start         = 1'b0;
      n_terms       = 4'd0;
      digits        = 32'h0;
      ops           = 7'h0;
      bus.out_ready = 1'b1;
      e_is_op       = 1'b0;
      e_digit       = 4'd0;
      e_op          = 1'b0;
      test_reset();
      test_enc();
      test_basic();
      test_single();
      test_stall();
      test_invalid();
      test_clr_mid();
      test_start_held();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
